// File: rtl/gpr_file_mp.sv
// gpr_file_mp: general-purpose register file with two write ports, two
// combinational read ports and a per-register busy scoreboard.
// After reset, a clear sequence zeroes one entry per cycle. ready rises
// DEPTH cycles after reset deasserts. Writes and allocations are dropped
// until ready is high.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   ready               - high once the clear sequence has finished
//   wen0/waddr0/wdata0  - write port 0
//   wen1/waddr1/wdata1  - write port 1; on an address collision, port 1 wins
//   raddr1/2, rdata1/2  - asynchronous read ports
//   rbusy1/2            - busy bit for raddr1/raddr2
//   alloc_en/alloc_addr - marks a register as having a pending producer
// Optional build macro GPR_FILE_BYPASS_EN forwards same-cycle writes (and
// the busy clears they cause) to the read ports.
// Register 0 is hardwired: it always reads 0 and is never busy.
module gpr_file_mp #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            wen0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            wen1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rbusy1,
    output logic            rbusy2,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [AW-1:0]     clr_ptr;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Qualified requests. Register 0 and the CLEAR state filter everything out.
    logic wr0_ok, wr1_ok, al_ok;
    assign wr0_ok = ready && wen0 && (waddr0 != '0);
    assign wr1_ok = ready && wen1 && (waddr1 != '0);
    assign al_ok  = ready && alloc_en && (alloc_addr != '0);

    // Clear-sequence FSM. ready is registered with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(DEPTH - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                    ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset. It is zeroed by the clear sequence.
    // Port 1 is assigned last, so it wins when both ports write the same entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr0_ok) mem[waddr0] <= wdata0;
                if (wr1_ok) mem[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard. The set is assigned last, so it wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (wr0_ok) busy[waddr0]     <= 1'b0;
            if (wr1_ok) busy[waddr1]     <= 1'b0;
            if (al_ok)  busy[alloc_addr] <= 1'b1;
        end
    end

    always_comb begin
        rdata1 = '0;
        rbusy1 = busy[raddr1];
        if (ready && raddr1 != '0) begin
            rdata1 = mem[raddr1];
`ifdef GPR_FILE_BYPASS_EN
            if (wr0_ok && waddr0 == raddr1) rdata1 = wdata0;
            if (wr1_ok && waddr1 == raddr1) rdata1 = wdata1;
            if (((wr0_ok && waddr0 == raddr1) || (wr1_ok && waddr1 == raddr1)) &&
                !(al_ok && alloc_addr == raddr1))
                rbusy1 = 1'b0;
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        rbusy2 = busy[raddr2];
        if (ready && raddr2 != '0) begin
            rdata2 = mem[raddr2];
`ifdef GPR_FILE_BYPASS_EN
            if (wr0_ok && waddr0 == raddr2) rdata2 = wdata0;
            if (wr1_ok && waddr1 == raddr2) rdata2 = wdata1;
            if (((wr0_ok && waddr0 == raddr2) || (wr1_ok && waddr1 == raddr2)) &&
                !(al_ok && alloc_addr == raddr2))
                rbusy2 = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: self-checking bench for gpr_file_mp at default parameters.
// Table vectors push their expected read-back values to a queue. The queue is
// popped after the edge. Hand-written sequences cover reset, clear and bypass.
module tb_gpr_file_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            ready;
    logic            wen0, wen1, alloc_en;
    logic [AW-1:0]   waddr0, waddr1, raddr1, raddr2, alloc_addr;
    logic [XLEN-1:0] wdata0, wdata1, rdata1, rdata2;
    logic            rbusy1, rbusy2;

    always #5 clk = ~clk;

    gpr_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    typedef struct {
        logic            wen0;
        logic [AW-1:0]   waddr0;
        logic [XLEN-1:0] wdata0;
        logic            wen1;
        logic [AW-1:0]   waddr1;
        logic [XLEN-1:0] wdata1;
        logic            alloc_en;
        logic [AW-1:0]   alloc_addr;
        logic [AW-1:0]   raddr1;
        logic [AW-1:0]   raddr2;
        logic [XLEN-1:0] e_rd1;
        logic [XLEN-1:0] e_rd2;
        logic            e_rb1;
        logic            e_rb2;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic            rb1;
        logic            rb2;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        wen0 = 0; waddr0 = '0; wdata0 = '0;
        wen1 = 0; waddr1 = '0; wdata1 = '0;
        alloc_en = 0; alloc_addr = '0;
    endtask

    // Counts rising edges until ready is high. The count starts at 'start'.
    task automatic wait_ready(input int start, output int n);
        n = start;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            idle();
            n++;
        end
    endtask

    initial begin
        int n;
        exp_t e;
        //             w0 a0  d0            w1 a1  d1            al aa   r1  r2   e_rd1         e_rd2         b1 b2
        vecs[0]  = '{1, 5'd5,  32'hAAAA0000, 1, 5'd5,  32'h0000BBBB, 0, 5'd0,  5'd5,  5'd0,  32'h0000BBBB, 32'h0,        0, 0};
        vecs[1]  = '{1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0000BBBB, 0, 0};
        vecs[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  5'd5,  32'h0,        32'h0000BBBB, 1, 0};
        vecs[3]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'h77,       1, 5'd7,  5'd7,  5'd7,  32'h77,       32'h77,       1, 1};
        vecs[4]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'h78,       0, 5'd0,  5'd7,  5'd0,  32'h78,       32'h0,        0, 0};
        vecs[5]  = '{1, 5'd3,  32'h55,       1, 5'd4,  32'h66,       0, 5'd0,  5'd3,  5'd4,  32'h55,       32'h66,       0, 0};
        vecs[6]  = '{1, 5'd10, 32'h1,        0, 5'd0,  32'h0,        1, 5'd10, 5'd0,  5'd10, 32'h0,        32'h1,        0, 1};
        vecs[7]  = '{1, 5'd10, 32'h2,        0, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd10, 32'h2,        32'h2,        0, 0};
        vecs[8]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd31, 5'd31, 5'd3,  32'h0,        32'h55,       1, 0};
        vecs[9]  = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd30, 32'h12,       0, 5'd0,  5'd31, 5'd30, 32'hFFFFFFFF, 32'h12,       0, 0};
        vecs[10] = '{1, 5'd9,  32'h11,       0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd0,  32'h11,       32'h0,        0, 0};
        vecs[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd3,  32'h11,       32'h55,       1, 0};

        // Reset, then clear. A write and an alloc are held to entry 2 for the
        // whole clear sequence. Both must be dropped.
        idle(); raddr1 = 5'd2; raddr2 = 5'd5;
        reset = 1;
        @(posedge clk); #1;
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rbusy1", 32'(rbusy1), 32'h0);
        @(negedge clk);
        reset = 0;
        wen0 = 1; waddr0 = 5'd2; wdata0 = 32'hDEADBEEF; alloc_en = 1; alloc_addr = 5'd2;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        idle();
        check("clear_cycles", 32'(n), 32'(DEPTH));
        check("clear_drop_rdata", rdata1, 32'h0);
        check("clear_drop_busy", 32'(rbusy1), 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i); raddr2 = AW'(DEPTH - 1 - i);
            #1;
            check($sformatf("zero_rd1[%0d]", i), rdata1, 32'h0);
            check($sformatf("zero_rd2[%0d]", DEPTH - 1 - i), rdata2, 32'h0);
        end

        // Table vectors: drive at negedge, expected values enter the scoreboard,
        // and the read-back after the edge is checked against the popped entry.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            wen0 = vecs[v].wen0; waddr0 = vecs[v].waddr0; wdata0 = vecs[v].wdata0;
            wen1 = vecs[v].wen1; waddr1 = vecs[v].waddr1; wdata1 = vecs[v].wdata1;
            alloc_en = vecs[v].alloc_en; alloc_addr = vecs[v].alloc_addr;
            raddr1 = vecs[v].raddr1; raddr2 = vecs[v].raddr2;
            exp_q.push_back('{vecs[v].e_rd1, vecs[v].e_rd2, vecs[v].e_rb1, vecs[v].e_rb2});
            @(posedge clk); #1;
            idle();
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d_rdata1", v), rdata1, e.rd1);
            check($sformatf("vec%0d_rdata2", v), rdata2, e.rd2);
            check($sformatf("vec%0d_rbusy1", v), 32'(rbusy1), 32'(e.rb1));
            check($sformatf("vec%0d_rbusy2", v), 32'(rbusy2), 32'(e.rb2));
        end

        // Same-cycle write to busy register 9 while it is being read.
        @(negedge clk);
        wen0 = 1; waddr0 = 5'd9; wdata0 = 32'h12345678; raddr1 = 5'd3; raddr2 = 5'd9;
        #1;
`ifdef GPR_FILE_BYPASS_EN
        check("bypass_rdata2", rdata2, 32'h12345678);
        check("bypass_rbusy2", 32'(rbusy2), 32'h0);
`else
        check("nobypass_rdata2", rdata2, 32'h11);
        check("nobypass_rbusy2", 32'(rbusy2), 32'h1);
`endif
        @(posedge clk); #1;
        idle(); #1;
        check("after_write_rdata2", rdata2, 32'h12345678);
        check("after_write_rbusy2", 32'(rbusy2), 32'h0);

        // Reset from READY. Register 3 holds 0x55 and is made busy. A write
        // issued mid-clear must be dropped, and register 3 must end up 0.
        @(negedge clk);
        alloc_en = 1; alloc_addr = 5'd3;
        @(posedge clk); #1;
        idle(); #1;
        check("pre_reset_busy3", 32'(rbusy1), 32'h1);
        check("pre_reset_rd3", rdata1, 32'h55);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        check("rst2_ready", 32'(ready), 32'h0);
        check("rst2_busy3", 32'(rbusy1), 32'h0);
        check("rst2_rd3", rdata1, 32'h0);
        @(negedge clk);
        reset = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        wen0 = 1; waddr0 = 5'd3; wdata0 = 32'hAB; alloc_en = 1; alloc_addr = 5'd3;
        @(posedge clk); #1;
        idle(); #1;
        check("midclear_ready", 32'(ready), 32'h0);
        check("midclear_busy3", 32'(rbusy1), 32'h0);
        wait_ready(11, n);
        check("rst2_clear_cycles", 32'(n), 32'(DEPTH));
        #1;
        check("rst2_final_rd3", rdata1, 32'h0);
        check("rst2_final_busy3", 32'(rbusy1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpr_file_mp.md
GPR_FILE_MP -- requirements
Module: gpr_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of every register in bits.
REQ-002 Parameter DEPTH, default 32, register count; power of two, minimum 4.
REQ-003 Derived parameter AW = $clog2(DEPTH), register address width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 ready  output  1  high once the clear sequence completes; accesses are valid only while high.
REQ-007 wen0 / waddr0 / wdata0  input  1 / AW / XLEN  write port 0.
REQ-008 wen1 / waddr1 / wdata1  input  1 / AW / XLEN  write port 1; has priority over port 0.
REQ-009 raddr1, raddr2  input  AW each  read addresses.
REQ-010 rdata1, rdata2  output  XLEN each  read data, combinational.
REQ-011 rbusy1, rbusy2  output  1 each  scoreboard busy bit of raddr1 / raddr2, combinational.
REQ-012 alloc_en / alloc_addr  input  1 / AW  marks a register as having a pending producer.

Function
REQ-013 Register 0 is hardwired: it reads 0, it is never busy, and writes or allocations to it are ignored.
REQ-014 Write port w with wen=1, waddr!=0 and ready=1 updates the array at the next rising edge.
REQ-015 If both ports write the same address in the same cycle, the wdata1 value is stored.
REQ-016 The read path is asynchronous: rdata = array[raddr], or 0 when raddr=0 or ready=0.
REQ-017 The scoreboard holds one busy bit per register.
REQ-018 Busy is set at the edge when alloc_en=1 and ready=1.
REQ-019 Busy is cleared at the edge when either write port writes that register.
REQ-020 If a set and a clear hit the same register in one cycle, set wins.
REQ-021 The FSM has two states: CLEAR and READY.
REQ-022 In CLEAR, a counter clr_ptr starts at 0 and one entry array[clr_ptr] is zeroed per cycle.
REQ-023 In CLEAR, the FSM moves to READY at the edge after clr_ptr = DEPTH-1, so ready rises DEPTH cycles after reset deasserts.
REQ-024 In CLEAR, all write and allocation requests are ignored (dropped, not queued).
REQ-025 clr_ptr wraps naturally at DEPTH-1 and is not used in READY.
REQ-026 With XLEN or DEPTH changed, the width of every port follows its parameter; there is no truncation or extension inside the block.

Reset
REQ-027 When reset=1 at an edge: state <= CLEAR, clr_ptr <= 0, all busy bits <= 0, ready <= 0.
REQ-028 Reset asserted mid-CLEAR or in READY restarts the clear sequence from entry 0.
REQ-029 Reset values: ready=0, rbusy1/2=0, rdata1/2=0; the array holds all zeros once ready rises.

Configuration
REQ-030 Macro GPR_FILE_BYPASS_EN enables write-to-read forwarding.
REQ-031 With GPR_FILE_BYPASS_EN defined, each rdata returns the wdata of a same-cycle write to raddr (port 1 over port 0).
REQ-032 With GPR_FILE_BYPASS_EN defined, each rbusy returns 0 when a same-cycle write clears that register and no same-cycle alloc targets it.
REQ-033 Without GPR_FILE_BYPASS_EN, reads return pre-edge array and busy contents; there is no forwarding logic.
REQ-034 Forwarding applies only when ready=1 and raddr!=0.

Verification
REQ-035 Reset for 1 cycle, then idle -> ready=0 for exactly DEPTH cycles (32 at default), then 1; reading every address returns 0.
REQ-036 wen0=1, waddr0=5, wdata0=0xAAAA0000 and wen1=1, waddr1=5, wdata1=0x0000BBBB in one cycle -> next cycle rdata1 at raddr1=5 reads 0x0000BBBB.
REQ-037 wen0=1, waddr0=0, wdata0=0xFFFFFFFF -> raddr1=0 reads 0; alloc_addr=0 -> rbusy stays 0.
REQ-038 alloc_en=1, alloc_addr=7 -> rbusy1=1 at raddr1=7; a later cycle with alloc_addr=7 plus wen1 to 7 -> busy stays 1; write alone to 7 -> busy 0.
REQ-039 Bypass build: wen0=1, waddr0=9, wdata0=0x12345678 with raddr2=9 in the same cycle -> rdata2=0x12345678 combinationally; non-bypass build returns the old value.
REQ-040 Write 0x55 to register 3, let ready=1, assert reset, then attempt a write 10 cycles later -> write ignored, ready=0, busy bits 0, register 3 reads 0 once ready rises.
